// File: rtl/seq_wrap_monitor.sv
// Sequence monitor for a free-running CW-bit wrap-around counter: checks +1 steps,
// counts wraps (saturating), and reports lock / sequence-error status.
module seq_wrap_monitor #(
    parameter int CW     = 3,
    parameter int WRAP_W = 8,
    parameter int LOCK_N = 4
) (
    input  logic              cl,
    input  logic              r,
    input  logic [CW-1:0]     cin,
    input  logic              clr,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              locked,
    output logic              seq_err,
    output logic              err_sticky,
    output logic [1:0]        state
);

    localparam int GR_W = $clog2(LOCK_N + 1);
    localparam logic [CW-1:0]     MAX_V  = '1;
    localparam logic [GR_W-1:0]   LOCK_V = GR_W'(LOCK_N);
    localparam logic [WRAP_W-1:0] WSAT   = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_TRACK  = 2'b01,
        S_LOCKED = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      prev_q, prev_d;
    logic [GR_W-1:0]    good_run_q, good_run_d;
    logic               wrap_q, wrap_d;
    logic [WRAP_W-1:0]  wrap_cnt_q, wrap_cnt_d;
    logic               locked_q, locked_d;
    logic               seq_err_q, seq_err_d;
    logic               err_sticky_q, err_sticky_d;

    logic [CW-1:0]      expected;
    logic               is_good;
    logic               is_restart;
    logic               wrap_evt;
    logic [GR_W-1:0]    good_run_inc;
    logic [WRAP_W-1:0]  cnt_base;

    // A zero after a non-max value is an upstream restart, not an error.
    assign expected     = prev_q + CW'(1);
    assign is_good      = (cin == expected);
    assign is_restart   = !is_good && (cin == '0) && (prev_q != MAX_V);
    assign wrap_evt     = is_good && (prev_q == MAX_V);
    assign good_run_inc = (good_run_q == LOCK_V) ? good_run_q : good_run_q + GR_W'(1);

    always_comb begin
        state_d    = state_q;
        prev_d     = cin;
        good_run_d = good_run_q;
        wrap_d     = 1'b0;
        seq_err_d  = 1'b0;
        case (state_q)
            S_TRACK: begin
                if (is_good) begin
                    good_run_d = good_run_inc;
                    wrap_d     = wrap_evt;
                    if (good_run_inc == LOCK_V) begin
                        state_d = S_LOCKED;
                    end
                end else if (is_restart) begin
                    good_run_d = '0;
                end else begin
                    good_run_d = '0;
                    seq_err_d  = 1'b1;
                end
            end
            S_LOCKED: begin
                if (is_good) begin
                    good_run_d = good_run_inc;
                    wrap_d     = wrap_evt;
                end else begin
                    good_run_d = '0;
                    state_d    = S_TRACK;
                    seq_err_d  = !is_restart;
                end
            end
            default: begin
                // IDLE (and the unused 11 encoding): first sample is only captured.
                good_run_d = '0;
                state_d    = S_TRACK;
            end
        endcase

        // clr is applied first so a same-edge wrap or error still registers.
        cnt_base     = clr ? '0 : wrap_cnt_q;
        wrap_cnt_d   = (wrap_d && (cnt_base != WSAT)) ? cnt_base + WRAP_W'(1) : cnt_base;
        err_sticky_d = seq_err_d | (!clr & err_sticky_q);
        locked_d     = (state_d == S_LOCKED);
    end

    always_ff @(posedge cl) begin
        if (!r) begin
            state_q      <= S_IDLE;
            prev_q       <= '0;
            good_run_q   <= '0;
            wrap_q       <= 1'b0;
            wrap_cnt_q   <= '0;
            locked_q     <= 1'b0;
            seq_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            good_run_q   <= good_run_d;
            wrap_q       <= wrap_d;
            wrap_cnt_q   <= wrap_cnt_d;
            locked_q     <= locked_d;
            seq_err_q    <= seq_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign wrap       = wrap_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign locked     = locked_q;
    assign seq_err    = seq_err_q;
    assign err_sticky = err_sticky_q;
    assign state      = state_q;

endmodule

// File: tb/tb_seq_wrap_monitor.sv
// Scoreboard bench for seq_wrap_monitor: directed steps push expected outputs,
// a negedge monitor pops and compares them (second instance uses WRAP_W=2).
module tb_seq_wrap_monitor;

    logic       clk;
    logic       rn;
    logic [2:0] cin;
    logic       clr;

    logic       wrap, locked, seq_err, err_sticky;
    logic [7:0] wrap_cnt;
    logic [1:0] state;

    logic       wrap2, locked2, seq_err2, err_sticky2;
    logic [1:0] wrap_cnt2;
    logic [1:0] state2;

    seq_wrap_monitor #(.CW(3), .WRAP_W(8), .LOCK_N(4)) dut (
        .cl(clk), .r(rn), .cin(cin), .clr(clr),
        .wrap(wrap), .wrap_cnt(wrap_cnt), .locked(locked),
        .seq_err(seq_err), .err_sticky(err_sticky), .state(state)
    );

    seq_wrap_monitor #(.CW(3), .WRAP_W(2), .LOCK_N(4)) dut2 (
        .cl(clk), .r(rn), .cin(cin), .clr(clr),
        .wrap(wrap2), .wrap_cnt(wrap_cnt2), .locked(locked2),
        .seq_err(seq_err2), .err_sticky(err_sticky2), .state(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ph;
        logic [15:0] idx;
        logic [1:0]  st;
        logic        w;
        logic [7:0]  cnt;
        logic        lk;
        logic        e;
        logic        s;
        logic        chk2;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [7:0]  cur_ph = 8'd0;
    logic [15:0] cur_idx = 16'd0;

    task automatic step(input logic rn_i, input logic [2:0] c, input logic clr_i,
                        input logic [1:0] st, input logic w, input logic [7:0] cnt,
                        input logic lk, input logic e, input logic s,
                        input logic chk2, input logic [1:0] cnt2);
        exp_t x;
        rn  = rn_i;
        cin = c;
        clr = clr_i;
        @(posedge clk);
        x = '{ph: cur_ph, idx: cur_idx, st: st, w: w, cnt: cnt, lk: lk, e: e, s: s,
              chk2: chk2, cnt2: cnt2};
        sb_q.push_back(x);
        $display("step ph%0d #%0d r=%0b cin=%0d clr=%0b", cur_ph, cur_idx, rn_i, c, clr_i);
        cur_idx = cur_idx + 16'd1;
        #1;
    endtask

    task automatic t(input logic [2:0] c, input logic [1:0] st, input logic w,
                     input logic [7:0] cnt, input logic lk, input logic e, input logic s);
        step(1'b1, c, 1'b0, st, w, cnt, lk, e, s, 1'b0, 2'd0);
    endtask

    task automatic chk(input string nm, input int act, input int req, input exp_t x);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL ph%0d #%0d %s got=%0d exp=%0d", x.ph, x.idx, nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk("state", int'(state), int'(x.st), x);
            chk("wrap", int'(wrap), int'(x.w), x);
            chk("wrap_cnt", int'(wrap_cnt), int'(x.cnt), x);
            chk("locked", int'(locked), int'(x.lk), x);
            chk("seq_err", int'(seq_err), int'(x.e), x);
            chk("err_sticky", int'(err_sticky), int'(x.s), x);
            if (x.chk2) chk("wrap_cnt_w2", int'(wrap_cnt2), int'(x.cnt2), x);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] c;
        logic [1:0] st;
        logic       w, lk;
        logic [7:0] cnt;
        int         nw;

        rn = 1'b0; cin = 3'd0; clr = 1'b0;

        // Phase 1: reset, then a clean 0..7,0..7,0 run
        cur_ph = 8'd1; cur_idx = 16'd0;
        step(1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int k = 1; k <= 17; k++) begin
            c   = 3'((k - 1) % 8);
            st  = (k >= 5) ? 2'd2 : 2'd1;
            lk  = (k >= 5);
            w   = (k == 9) || (k == 17);
            cnt = (k >= 17) ? 8'd2 : ((k >= 9) ? 8'd1 : 8'd0);
            t(c, st, w, cnt, lk, 1'b0, 1'b0);
        end

        // Phase 2: bad step 3->5 while locked, then relock across a wrap
        cur_ph = 8'd2; cur_idx = 16'd0;
        t(3'd1, 2'd2, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        t(3'd2, 2'd2, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        t(3'd3, 2'd2, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        t(3'd5, 2'd1, 1'b0, 8'd2, 1'b0, 1'b1, 1'b1);
        t(3'd6, 2'd1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1);
        t(3'd7, 2'd1, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1);
        t(3'd0, 2'd1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1);
        t(3'd1, 2'd2, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1);

        // Phase 3: upstream restart 5->0 while locked
        cur_ph = 8'd3; cur_idx = 16'd0;
        t(3'd2, 2'd2, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1);
        t(3'd3, 2'd2, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1);
        t(3'd4, 2'd2, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1);
        t(3'd5, 2'd2, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1);
        t(3'd0, 2'd1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1);
        t(3'd1, 2'd1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1);

        // Phase 5: clr interactions
        cur_ph = 8'd5; cur_idx = 16'd0;
        t(3'd2, 2'd1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1);
        t(3'd3, 2'd1, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1);
        t(3'd4, 2'd2, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1);
        t(3'd5, 2'd2, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1);
        t(3'd6, 2'd2, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1);
        t(3'd7, 2'd2, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1);
        t(3'd0, 2'd2, 1'b1, 8'd4, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 7; k++) t(3'(k), 2'd2, 1'b0, 8'd4, 1'b1, 1'b0, 1'b1);
        t(3'd0, 2'd2, 1'b1, 8'd5, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 7; k++) t(3'(k), 2'd2, 1'b0, 8'd5, 1'b1, 1'b0, 1'b1);
        step(1'b1, 3'd0, 1'b1, 2'd2, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 3'd2, 1'b1, 2'd1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        t(3'd3, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        t(3'd4, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        t(3'd5, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        t(3'd6, 2'd2, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        t(3'd7, 2'd2, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        t(3'd0, 2'd2, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 3'd1, 1'b1, 2'd2, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // Phase 6: reset while locked with wraps and sticky error
        cur_ph = 8'd6; cur_idx = 16'd0;
        t(3'd3, 2'd1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        t(3'd4, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        t(3'd5, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        t(3'd6, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        t(3'd7, 2'd2, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
        t(3'd0, 2'd2, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 7; k++) t(3'(k), 2'd2, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1);
        t(3'd0, 2'd2, 1'b1, 8'd2, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 7; k++) t(3'(k), 2'd2, 1'b0, 8'd2, 1'b1, 1'b0, 1'b1);
        t(3'd0, 2'd2, 1'b1, 8'd3, 1'b1, 1'b0, 1'b1);
        // reset with clr and a would-be bad step: reset must win
        step(1'b0, 3'd3, 1'b1, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        t(3'd6, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        t(3'd7, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        t(3'd0, 2'd1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
        t(3'd1, 2'd1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
        t(3'd2, 2'd2, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);

        // Phase 4: five wraps, WRAP_W=2 instance saturates at 3
        cur_ph = 8'd4; cur_idx = 16'd0;
        step(1'b0, 3'd0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        nw = 0;
        for (int k = 1; k <= 41; k++) begin
            c = 3'((k - 1) % 8);
            w = (k > 1) && (c == 3'd0);
            if (w) nw++;
            st  = (k >= 5) ? 2'd2 : 2'd1;
            lk  = (k >= 5);
            cnt = 8'(nw);
            step(1'b1, c, 1'b0, st, w, cnt, lk, 1'b0, 1'b0, 1'b1,
                 (nw > 3) ? 2'd3 : 2'(nw));
        end

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain got=%0d exp=0 pending entries", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_wrap_monitor.md
Name: seq_wrap_monitor

Overview:
- Sits directly downstream of the free-running 3-bit wrap-around counter and consumes its count value every clock.
- Checks that the count advances by exactly +1 modulo 2^CW per cycle and detects wrap events (max -> 0).
- Accumulates a saturating wrap count and reports lock and sequence-error status to the control logic.

Parameters:
CW, 3, width of the monitored count (max value 2^CW-1)
WRAP_W, 8, width of the wrap counter output
LOCK_N, 4, consecutive good steps required to declare lock (LOCK_N >= 1)

Ports:
cl  input  1  clock; all logic on the rising edge
r  input  1  synchronous active-low reset (r=0 resets on the next cl rising edge)
cin  input  CW  count value from the upstream counter, sampled every cycle
clr  input  1  synchronous clear of wrap_cnt and err_sticky
wrap  output  1  one-cycle pulse per detected wrap
wrap_cnt  output  WRAP_W  saturating count of wraps
locked  output  1  high while in LOCKED
seq_err  output  1  one-cycle pulse per illegal step
err_sticky  output  1  set by any seq_err, cleared only by clr or reset
state  output  2  FSM state: IDLE=00, TRACK=01, LOCKED=10 (11 unused, decodes to IDLE)

Behaviour:
- Reset (r=0 at an edge): state=IDLE; prev=0; good_run=0; all outputs 0. Reset overrides clr and all events. Reset mid-lock drops lock immediately.
- All outputs are registered. An event on the cin sampled at edge k is visible after edge k, i.e. latency 1 cycle.
- prev holds cin from the previous edge. expected = (prev+1) mod 2^CW.
- Step classification at each edge, except in IDLE:
  - good: cin == expected.
  - restart: cin == 0 and prev != max. This is upstream reset, not an error.
  - bad: anything else, including hold (cin == prev).
- wrap_evt: good step with prev == max and cin == 0.
- IDLE: capture prev = cin; no checks; go to TRACK.
- TRACK:
  - good: good_run += 1, saturating at LOCK_N. When it reaches LOCK_N, go to LOCKED the same edge.
  - restart: good_run=0; stay in TRACK.
  - bad: seq_err=1, err_sticky=1, good_run=0; stay in TRACK.
- LOCKED:
  - good: stay.
  - restart: good_run=0; go to TRACK; no seq_err.
  - bad: seq_err=1, err_sticky=1, good_run=0; go to TRACK.
- wrap: pulses for any wrap_evt in TRACK or LOCKED, and is 0 in IDLE. wrap_cnt increments on each wrap and saturates at 2^WRAP_W-1 (no roll-over).
- clr:
  - clears wrap_cnt and err_sticky.
  - If a wrap occurs the same edge, wrap_cnt=1.
  - If seq_err occurs the same edge, err_sticky=1 (the new event wins).
  - clr does not affect state, good_run, prev, or the pulse outputs.
- good_run width: clog2(LOCK_N+1) bits.
- locked = (state == LOCKED), registered.
- Arithmetic: expected is computed in CW bits with natural wrap; wrap_cnt uses a WRAP_W-bit compare-to-all-ones before increment.

Test Plan:
1. Reset, then cin=0,1,...,7,0,...,7,0 on consecutive edges 1..17:
   - state=TRACK after edge 1; locked=1 after edge 5 (4 good steps).
   - wrap=1 for one cycle after edges 9 and 17; wrap_cnt=1 then 2.
   - seq_err never asserts.
2. Locked, then cin sequence 2,3,5:
   - seq_err=1 for one cycle after the edge sampling 5; err_sticky=1; locked=0; state=TRACK.
   - Continue 6,7,0,1: locked=1 again after the 4th good step; wrap still counted on 7->0.
3. Locked, then cin 4,5,0,1:
   - After the edge sampling 0: no seq_err, no wrap, locked=0, state=TRACK, wrap_cnt unchanged.
4. WRAP_W=2, five full 0..7 cycles:
   - wrap_cnt = 1,2,3,3,3; wrap still pulses on every wrap.
5. clr=1 on the edge that samples a 7->0 wrap, with wrap_cnt=5: wrap_cnt=1.
   - clr=1 on the edge of a bad step: err_sticky=1 and seq_err=1.
   - clr alone: wrap_cnt=0, err_sticky=0, locked unchanged.
6. Locked with wrap_cnt=3 and err_sticky=1, hold r=0 for one edge:
   - All outputs 0, state=IDLE.
   - Release with cin=6: the first sample is not checked (no seq_err), state=TRACK; then 7,0,1,2 gives locked=1 and wrap_cnt=1.
